// File: rtl/intersection_pkg.sv
// Shared types and constants for the multi-approach intersection controller.
package intersection_pkg;

  // Gray-coded controller states
  typedef enum logic [2:0] {
    ST_OFF     = 3'b000,
    ST_CLEAR   = 3'b001,
    ST_GREEN   = 3'b011,
    ST_FLICKER = 3'b010,
    ST_YELLOW  = 3'b110
  } state_t;

  // Per-approach lamp codes
  localparam logic [1:0] LIGHT_OFF    = 2'b00;
  localparam logic [1:0] LIGHT_RED    = 2'b01;
  localparam logic [1:0] LIGHT_YELLOW = 2'b10;
  localparam logic [1:0] LIGHT_GREEN  = 2'b11;

  // Timer load value for a phase of d ticks; a zero duration behaves as one tick
  function automatic int unsigned dur_load(input int unsigned d);
    return (d == 0) ? 0 : d - 1;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Tick-enabled down-counter. expired is high on the tick that ends a phase
// (count == 0 with tick); load takes priority over counting.
module phase_timer #(
  parameter int unsigned TW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  input  logic          tick,
  output logic          expired
);

  logic [TW-1:0] r_count;

  // Count register: reload on phase change, otherwise decrement on tick down to zero
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (tick && (r_count != '0)) begin
      r_count <= r_count - TW'(1);
    end
  end

  assign expired = tick && (r_count == '0);

endmodule

// File: rtl/intersection_controller.sv
// Round-robin multi-approach traffic-light controller.
// Optional feature macro: INTERSECTION_SKIP_IDLE_EN (demand-driven approach
// selection at clearance expiry; approaches without demand are skipped).
module intersection_controller
  import intersection_pkg::*;
#(
  parameter int unsigned N_DIR        = 2,
  parameter int unsigned TW           = 5,
  parameter int unsigned CLEAR_TIME   = 2,
  parameter int unsigned GREEN_TIME   = 30,
  parameter int unsigned FLICKER_TIME = 4,
  parameter int unsigned YELLOW_TIME  = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       tick,
  input  logic [N_DIR-1:0]           demand,
  output logic [2*N_DIR-1:0]         L_out,
  output logic [$clog2(N_DIR)-1:0]   phase_idx,
  output logic                       busy
);

  localparam int unsigned PW = $clog2(N_DIR);

  localparam logic [TW-1:0] LD_CLEAR   = TW'(dur_load(CLEAR_TIME));
  localparam logic [TW-1:0] LD_GREEN   = TW'(dur_load(GREEN_TIME));
  localparam logic [TW-1:0] LD_FLICKER = TW'(dur_load(FLICKER_TIME));
  localparam logic [TW-1:0] LD_YELLOW  = TW'(dur_load(YELLOW_TIME));

  state_t          r_state;
  state_t          w_next;
  logic [PW-1:0]   r_phase;
  logic [PW-1:0]   w_next_phase;
  logic [PW-1:0]   w_phase_inc;
  logic            r_flick;
  logic            r_stop_pending;
  logic            w_stop_req;
  logic            w_load;
  logic [TW-1:0]   w_load_val;
  logic            w_expired;

  phase_timer #(.TW(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (w_load),
    .load_val (w_load_val),
    .tick     (tick),
    .expired  (w_expired)
  );

  assign w_stop_req  = stop | r_stop_pending;
  assign w_phase_inc = (r_phase == PW'(N_DIR - 1)) ? '0 : r_phase + PW'(1);

`ifdef INTERSECTION_SKIP_IDLE_EN
  logic          w_found;
  logic [PW-1:0] w_pick;

  // Round-robin search for the next demanding approach, current approach last
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_phase;
    for (int unsigned k = 1; k <= N_DIR; k++) begin
      if (!w_found && demand[PW'((int'(r_phase) + k) % N_DIR)]) begin
        w_found = 1'b1;
        w_pick  = PW'((int'(r_phase) + k) % N_DIR);
      end
    end
  end
`else
  logic w_unused_demand;
  assign w_unused_demand = ^demand;
`endif

  // Next-state, timer reload and approach selection
  always_comb begin
    w_next       = r_state;
    w_next_phase = r_phase;
    w_load       = 1'b0;
    w_load_val   = '0;
    case (r_state)
      ST_OFF: begin
        if (start && !stop) begin
          w_next     = ST_CLEAR;
          w_load     = 1'b1;
          w_load_val = LD_CLEAR;
        end
      end
      ST_CLEAR: begin
        if (w_expired) begin
          if (w_stop_req) begin
            w_next = ST_OFF;
          end else begin
`ifdef INTERSECTION_SKIP_IDLE_EN
            w_load = 1'b1;
            if (w_found) begin
              w_next       = ST_GREEN;
              w_next_phase = w_pick;
              w_load_val   = LD_GREEN;
            end else begin
              w_load_val   = LD_CLEAR;
            end
`else
            w_next     = ST_GREEN;
            w_load     = 1'b1;
            w_load_val = LD_GREEN;
`endif
          end
        end
      end
      ST_GREEN: begin
        // a stop request cuts green short without waiting for a tick
        if (w_expired || w_stop_req) begin
          w_next     = ST_FLICKER;
          w_load     = 1'b1;
          w_load_val = LD_FLICKER;
        end
      end
      ST_FLICKER: begin
        if (w_expired) begin
          w_next     = ST_YELLOW;
          w_load     = 1'b1;
          w_load_val = LD_YELLOW;
        end
      end
      ST_YELLOW: begin
        if (w_expired) begin
          w_next     = ST_CLEAR;
          w_load     = 1'b1;
          w_load_val = LD_CLEAR;
`ifndef INTERSECTION_SKIP_IDLE_EN
          // with demand skipping the approach is chosen at clearance expiry instead
          w_next_phase = w_phase_inc;
`endif
        end
      end
      default: begin
        w_next = ST_OFF;
      end
    endcase
  end

  // State, approach index and stop flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_OFF;
      r_phase        <= '0;
      r_stop_pending <= 1'b0;
    end else begin
      r_state <= w_next;
      r_phase <= w_next_phase;
      if (w_next == ST_OFF) begin
        r_stop_pending <= 1'b0;
      end else if (stop) begin
        r_stop_pending <= 1'b1;
      end
    end
  end

  // Flicker phase: dark on entry to FLICKER, toggles on every tick while flickering
  always_ff @(posedge clk) begin
    if (reset || (r_state != ST_FLICKER)) begin
      r_flick <= 1'b0;
    end else if (tick) begin
      r_flick <= ~r_flick;
    end
  end

  // Moore lamp decode from registered state only
  always_comb begin
    L_out = '0;
    for (int unsigned i = 0; i < N_DIR; i++) begin
      if (r_state == ST_OFF) begin
        L_out[2*i +: 2] = LIGHT_OFF;
      end else if (PW'(i) != r_phase) begin
        L_out[2*i +: 2] = LIGHT_RED;
      end else begin
        case (r_state)
          ST_GREEN:   L_out[2*i +: 2] = LIGHT_GREEN;
          ST_FLICKER: L_out[2*i +: 2] = r_flick ? LIGHT_GREEN : LIGHT_OFF;
          ST_YELLOW:  L_out[2*i +: 2] = LIGHT_YELLOW;
          default:    L_out[2*i +: 2] = LIGHT_RED;
        endcase
      end
    end
  end

  assign phase_idx = r_phase;
  assign busy      = (r_state != ST_OFF);

endmodule

// File: doc/intersection_controller.md
# intersection_controller

Parametrised multi-approach traffic-light controller with an integrated phase timer. It sequences N_DIR approaches round-robin: all-red clearance, then green, flickering green, and yellow on the active approach. It generalises the single-light controller to many channels with configurable phase durations, a tick-enable time base and a controlled stop. It sits between the system tick generator and the per-approach lamp drivers.

## Interface
- N_DIR, 2: number of approaches; legal range 2–8.
- TW, 5: phase timer width in bits.
- CLEAR_TIME, 2: all-red clearance length in ticks.
- GREEN_TIME, 30: solid-green length in ticks.
- FLICKER_TIME, 4: flickering-green length in ticks.
- YELLOW_TIME, 3: yellow length in ticks.
- A duration of 0 behaves as 1. Durations must fit in TW bits.

- clk  in  1  clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  level; leaves OFF.
- stop  in  1  single-cycle pulse; requests an orderly shutdown.
- tick  in  1  time-base enable; the timer advances only when this is 1.
- demand  in  N_DIR  per-approach vehicle request; used only with SKIP_IDLE_EN.
- L_out  out  2*N_DIR  L_out[2i+1:2i] is approach i: 00 OFF, 01 RED, 10 YELLOW, 11 GREEN.
- phase_idx  out  $clog2(N_DIR)  active approach.
- busy  out  1  high in every state except OFF.

## Operation
- States: OFF, CLEAR, GREEN, FLICKER, YELLOW.
- Outputs are a Moore decode of the registered state, phase_idx and flicker phase. There is no combinational path from inputs to outputs.
- **OFF:** all L_out = 00. start=1 → CLEAR, timer loaded with CLEAR_TIME-1.
- **CLEAR:** all approaches 01. On expiry:
  - stop_pending → OFF;
  - otherwise → GREEN on the selected approach, with the timer loaded.
- **GREEN:** active approach 11, all others 01. On expiry → FLICKER.
- **FLICKER:** the active lamp starts at 00 and toggles 00/11 on every tick; others stay 01. On expiry → YELLOW.
- **YELLOW:** active approach 10, others 01. On expiry → CLEAR, and phase_idx advances to (phase_idx+1) mod N_DIR.
- **Timer:** a down-counter that decrements on tick.
  - Expiry condition: count==0 && tick.
  - Each state therefore lasts exactly D ticks.
  - The timer reloads in the same cycle as the state change.
- **stop:**
  - A stop pulse sets stop_pending. The flag clears on entry to OFF.
  - stop during GREEN truncates the green: next cycle → FLICKER with a full FLICKER_TIME.
  - stop during FLICKER or YELLOW lets the phase complete normally.
- **Simultaneous start and stop in OFF:** stop wins; the controller stays in OFF.
- start is ignored outside OFF.
- **Reset:** highest priority, takes effect mid-phase. Result: state OFF, phase_idx=0, timer=0, stop_pending=0, L_out all 00, busy=0.

## Timing
- start sampled at edge k → CLEAR visible after edge k, and busy=1 in the same cycle.
- With tick tied to 1, one full approach cycle is CLEAR+GREEN+FLICKER+YELLOW clocks.
- When tick=0, state and timer hold and the flicker toggle freezes.
- phase_idx changes only on the YELLOW→CLEAR edge, or on the CLEAR→GREEN edge when SKIP_IDLE_EN is defined.

## Configuration
- **INTERSECTION_SKIP_IDLE_EN defined:**
  - At CLEAR expiry the next green goes to the first approach, searching round-robin from phase_idx+1 inclusive of phase_idx itself last, whose demand bit is 1.
  - If no demand bit is set, the controller stays in CLEAR (all red) and reloads CLEAR_TIME.
  - stop_pending still exits to OFF.
- **Not defined:** demand is ignored and the controller uses the strict round-robin described above.

## Structure
- **intersection_pkg** contains:
  - the state enum (3-bit Gray encoding: OFF 000, CLEAR 001, GREEN 011, FLICKER 010, YELLOW 110);
  - the light-code constants LIGHT_OFF, LIGHT_RED, LIGHT_YELLOW, LIGHT_GREEN.
- **Sub-module phase_timer** (parameter TW):
  - ports clk, reset, load, load_val, tick, expired;
  - instantiated once.

## Test plan
All scenarios use N_DIR=2, CLEAR=2, GREEN=4, FLICKER=2, YELLOW=3, tick=1 unless stated.
1. **Basic sequence:** reset, then start at cycle 0. Required L_out:
   - cycles 1–2: 0101;
   - cycles 3–6: 0111;
   - cycles 7–8: 0100, then 0111;
   - cycles 9–11: 0110;
   - cycles 12–13: 0101;
   - cycles 14–17: 1101, with phase_idx=1.
2. **Tick gating:** tick high one cycle in three. Every phase lasts 3× its duration in clocks, and L_out is stable while tick=0.
3. **Stop during GREEN:** stop at cycle 4 → FLICKER at cycle 5, YELLOW for 3 cycles, CLEAR for 2 cycles, then OFF with L_out=0000 and busy=0.
4. **Reset mid-YELLOW:** assert reset → next cycle L_out=0000, phase_idx=0, busy=0. A subsequent start repeats scenario 1 exactly.
5. **Start and stop together in OFF:** both high in the same cycle → the controller stays in OFF.
6. **Skip idle (INTERSECTION_SKIP_IDLE_EN):**
   - demand=2'b10 → only approach 1 ever goes green.
   - demand=0 → L_out holds 0101 indefinitely.
   - demand set to 2'b01 later → approach 0 goes green after the current CLEAR expires.
